// File: rtl/rv32_load_store_unit.sv
// RV32 load/store unit: one req/ack data-memory transaction per load or store, with load formatting.
// Optional MISALIGN_TRAP_EN macro turns misaligned H/W accesses into immediate errors.
module rv32_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] data_addr_bus,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data_reg_d1,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          illegal;
    logic          misalign;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_fmt;

    always_comb begin
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                  (store && funct3[2]);
`ifdef MISALIGN_TRAP_EN
        misalign = ((funct3[1:0] == 2'b01) && data_addr_bus[0]) ||
                   ((funct3[1:0] == 2'b10) && (data_addr_bus[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Load result is formatted from the latched address/size so mem_rdata only matters with ack.
    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (load || store) begin
                    if (illegal || misalign) begin
                        state_d = ERR;
                    end else begin
                        state_d = REQ;
                        addr_d  = data_addr_bus;
                        f3_d    = funct3;
                        we_d    = store;
                        cnt_d   = '0;
                        case (funct3[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << data_addr_bus[1:0];
                                wdata_d = {4{store_data[7:0]}};
                            end
                            2'b01: begin
                                be_d    = data_addr_bus[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{store_data[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = store_data;
                            end
                        endcase
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = RESP;
                    if (!we_q) begin
                        rdata_d = ld_fmt;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if ((TIMEOUT_CYCLES != 0) && (cnt_d == TO_CNT)) begin
                        state_d = ERR;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_we      = we_q;
    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign data_reg_d1 = rdata_q;
    assign lsu_busy    = (state_q != IDLE);
    assign lsu_done    = (state_q == RESP) || (state_q == ERR);
    assign lsu_err     = (state_q == ERR);

endmodule
